alu_seq_ctrl: RTL and testbench

//  Multi-byte operation sequencer for the 8-bit combinational ALU.
//  - On a start request it reads operand bytes from data memory and drives the ALU one byte per step.
//  - Chains the carry for ADD, accumulates popcount totals, and writes results back to memory.
//  - Sits between the core's control logic and the ALU/data-memory ports; it owns alu_cmd/inA/acc/sc_i while busy.

---
 rtl/alu_seq_ctrl_if.sv | 56 +++++
 rtl/alu_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - command, data-memory and ALU bus bundle for the multi-byte ALU sequencer
//
// Groups every non-clock/reset signal of alu_seq_ctrl.
//   master : the sequencer side (drives busy/done/err/carry_out, memory strobes, ALU operands)
//   slave  : the environment side (core control, data memory, combinational ALU)
// Signals:
//   start/op/a_base/b_base/dst_base/len  command request from the core
//   busy/done/err/carry_out              command status back to the core
//   mem_addr/mem_ren/mem_rdata           data-memory read port (rdata valid the cycle after ren)
//   mem_wen/mem_wdata                    data-memory write port
//   alu_cmd/alu_inA/alu_acc/alu_sc_i     ALU operand drive
//   alu_rslt/alu_sc_o                    combinational ALU result and carry
interface alu_seq_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 4
);
   logic              start;
   logic [1:0]        op;
   logic [ADDR_W-1:0] a_base;
   logic [ADDR_W-1:0] b_base;
   logic [ADDR_W-1:0] dst_base;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic              err;
   logic              carry_out;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ren;
   logic [7:0]        mem_rdata;
   logic              mem_wen;
   logic [7:0]        mem_wdata;
   logic [3:0]        alu_cmd;
   logic [7:0]        alu_inA;
   logic [7:0]        alu_acc;
   logic              alu_sc_i;
   logic [7:0]        alu_rslt;
   logic              alu_sc_o;

   modport master (
      input  start, op, a_base, b_base, dst_base, len,
      output busy, done, err, carry_out,
      output mem_addr, mem_ren, mem_wen, mem_wdata,
      input  mem_rdata,
      output alu_cmd, alu_inA, alu_acc, alu_sc_i,
      input  alu_rslt, alu_sc_o
   );

   modport slave (
      output start, op, a_base, b_base, dst_base, len,
      input  busy, done, err, carry_out,
      input  mem_addr, mem_ren, mem_wen, mem_wdata,
      output mem_rdata,
      input  alu_cmd, alu_inA, alu_acc, alu_sc_i,
      output alu_rslt, alu_sc_o
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-byte ADD/XOR/POPCNT sequencer driving an 8-bit combinational ALU
//
// Reads operand bytes from data memory, runs them through the ALU one byte per step,
// chains the ADD carry, accumulates the POPCNT total and writes results back.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; returns to IDLE with every output at 0
//   bus    alu_seq_ctrl_if.master (command, status, data-memory and ALU signals)
// Ops: 00 ADD, 01 XOR, 10 POPCNT, 11 reserved (completes at once with err).
module alu_seq_ctrl #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_seq_ctrl_if.master bus
);
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_XOR = 2'b01;
   localparam logic [1:0] OP_POP = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_ACC, S_WR, S_DONE
   } state_t;

   state_t            state;
   logic [1:0]        op_r;
   logic [ADDR_W-1:0] a_base_r;
   logic [ADDR_W-1:0] b_base_r;
   logic [ADDR_W-1:0] dst_base_r;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  i_r;
   logic              carry_r;
   logic [7:0]        total_r;
   logic [7:0]        a_r;
   logic [7:0]        r_r;

   logic [LEN_W-1:0]  i_nxt;
   logic              last_byte;

   assign i_nxt     = i_r + LEN_W'(1);
   assign last_byte = (i_nxt == len_r);

   // Memory/status outputs are registered: each transition loads the values the next state presents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         op_r          <= '0;
         a_base_r      <= '0;
         b_base_r      <= '0;
         dst_base_r    <= '0;
         len_r         <= '0;
         i_r           <= '0;
         carry_r       <= 1'b0;
         total_r       <= '0;
         a_r           <= '0;
         r_r           <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.carry_out <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_ren   <= 1'b0;
         bus.mem_wen   <= 1'b0;
         bus.mem_wdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op_r       <= bus.op;
                  a_base_r   <= bus.a_base;
                  b_base_r   <= bus.b_base;
                  dst_base_r <= bus.dst_base;
                  len_r      <= bus.len;
                  if (bus.op == OP_RSV) begin
                     state    <= S_DONE;
                     bus.done <= 1'b1;
                     bus.err  <= 1'b1;
                  end else if (bus.len == '0) begin
                     state    <= S_DONE;
                     bus.done <= 1'b1;
                  end else begin
                     i_r          <= '0;
                     carry_r      <= 1'b0;
                     total_r      <= '0;
                     state        <= S_RD_A;
                     bus.busy     <= 1'b1;
                     bus.mem_ren  <= 1'b1;
                     bus.mem_addr <= bus.a_base;
                  end
               end
            end
            S_RD_A: begin
               state <= S_RD_B;
               if (op_r != OP_POP) begin
                  bus.mem_addr <= b_base_r + ADDR_W'(i_r);
               end else begin
                  bus.mem_ren <= 1'b0;
               end
            end
            S_RD_B: begin
               a_r         <= bus.mem_rdata;
               bus.mem_ren <= 1'b0;
               state       <= S_EXEC;
            end
            S_EXEC: begin
               r_r <= bus.alu_rslt;
               if (op_r == OP_ADD) begin
                  carry_r <= bus.alu_sc_o;
               end
               if (op_r == OP_POP) begin
                  state <= S_ACC;
               end else begin
                  state         <= S_WR;
                  bus.mem_wen   <= 1'b1;
                  bus.mem_addr  <= dst_base_r + ADDR_W'(i_r);
                  bus.mem_wdata <= bus.alu_rslt;
               end
            end
            S_ACC: begin
               total_r <= bus.alu_rslt;
               if (!last_byte) begin
                  i_r          <= i_nxt;
                  state        <= S_RD_A;
                  bus.mem_ren  <= 1'b1;
                  bus.mem_addr <= a_base_r + ADDR_W'(i_nxt);
               end else begin
                  // POPCNT produces one result byte, always at dst_base.
                  state         <= S_WR;
                  bus.mem_wen   <= 1'b1;
                  bus.mem_addr  <= dst_base_r;
                  bus.mem_wdata <= bus.alu_rslt;
               end
            end
            S_WR: begin
               bus.mem_wen <= 1'b0;
               if ((op_r != OP_POP) && !last_byte) begin
                  i_r          <= i_nxt;
                  state        <= S_RD_A;
                  bus.mem_ren  <= 1'b1;
                  bus.mem_addr <= a_base_r + ADDR_W'(i_nxt);
               end else begin
                  state         <= S_DONE;
                  bus.busy      <= 1'b0;
                  bus.done      <= 1'b1;
                  bus.carry_out <= (op_r == OP_ADD) && carry_r;
               end
            end
            S_DONE: begin
               bus.done      <= 1'b0;
               bus.err       <= 1'b0;
               bus.carry_out <= 1'b0;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ALU drive is decoded from the registered state. Operand B only arrives on mem_rdata
   // during EXEC, so it feeds alu_acc directly and the ALU result is captured into r_r
   // at the end of that same cycle.
   always_comb begin
      bus.alu_cmd  = 4'b0000;
      bus.alu_inA  = 8'h00;
      bus.alu_acc  = 8'h00;
      bus.alu_sc_i = 1'b0;
      case (state)
         S_EXEC: begin
            bus.alu_inA = a_r;
            case (op_r)
               OP_ADD: begin
                  bus.alu_cmd  = 4'b0100;
                  bus.alu_acc  = bus.mem_rdata;
                  bus.alu_sc_i = carry_r;
               end
               OP_XOR: begin
                  bus.alu_cmd = 4'b0010;
                  bus.alu_acc = bus.mem_rdata;
               end
               OP_POP: bus.alu_cmd = 4'b0011;
               default: bus.alu_inA = 8'h00;
            endcase
         end
         S_ACC: begin
            // Add this byte's popcount into the running total; ALU carry-out is dropped.
            bus.alu_cmd = 4'b0100;
            bus.alu_inA = r_r;
            bus.alu_acc = total_r;
         end
         default: bus.alu_cmd = 4'b0000;
      endcase
   end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl with memory, ALU and reference model
module tb_alu_seq_ctrl;
   localparam int ADDR_W = 8;
   localparam int LEN_W  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   alu_seq_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   alu_seq_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mem     [0:255];
   logic [7:0] exp_mem [0:255];
   int ren_cnt = 0;
   int wen_cnt = 0;
   int done_cnt = 0;
   int overlap_cnt = 0;
   logic [7:0] rd_addr_q [$];

   // Combinational 8-bit ALU.
   always_comb begin
      bus.alu_rslt = 8'h00;
      bus.alu_sc_o = 1'b0;
      case (bus.alu_cmd)
         4'b0100: {bus.alu_sc_o, bus.alu_rslt} = {1'b0, bus.alu_inA} + {1'b0, bus.alu_acc} + {8'h00, bus.alu_sc_i};
         4'b0010: bus.alu_rslt = bus.alu_inA ^ bus.alu_acc;
         4'b0011: bus.alu_rslt = 8'($countones(bus.alu_inA));
         default: bus.alu_rslt = 8'h00;
      endcase
   end

   // Data memory with registered read plus bus activity counters.
   always @(posedge clk) begin
      if (bus.mem_ren) begin
         bus.mem_rdata <= mem[bus.mem_addr];
         ren_cnt++;
         rd_addr_q.push_back(bus.mem_addr);
      end
      if (bus.mem_wen) begin
         mem[bus.mem_addr] = bus.mem_wdata;
         wen_cnt++;
      end
      if (bus.mem_ren && bus.mem_wen) overlap_cnt++;
      if (bus.done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: treat the operation as a byte-serial loop over an array copy of memory.
   task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic [3:0] len,
                        output int lat, output logic err, output logic cout,
                        output int nren, output int nwen);
      int c;
      int s;
      int tot;
      logic [7:0] ab, bb, db;
      for (int k = 0; k < 256; k++) exp_mem[k] = mem[k];
      err  = (op == 2'd3);
      cout = 1'b0;
      c    = 0;
      tot  = 0;
      if (op == 2'd3 || len == 0) begin
         lat = 1; nren = 0; nwen = 0;
         return;
      end
      for (int k = 0; k < int'(len); k++) begin
         ab = a + 8'(k);
         bb = b + 8'(k);
         db = d + 8'(k);
         if (op == 2'd0) begin
            s = int'(exp_mem[ab]) + int'(exp_mem[bb]) + c;
            exp_mem[db] = 8'(s);
            c = s / 256;
         end else if (op == 2'd1) begin
            exp_mem[db] = exp_mem[ab] ^ exp_mem[bb];
         end else begin
            tot = tot + $countones(exp_mem[ab]);
         end
      end
      if (op == 2'd2) begin
         exp_mem[d] = 8'(tot % 256);
         lat = 4 * int'(len) + 2; nren = int'(len); nwen = 1;
      end else begin
         lat = 4 * int'(len) + 1; nren = 2 * int'(len); nwen = int'(len);
      end
      cout = (op == 2'd0) && (c != 0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] d, input logic [3:0] len,
                         input int poke_at);
      int lat, nren, nwen, r0, w0, d0, o0, cyc, diffs;
      logic e, co;
      model(op, a, b, d, len, lat, e, co, nren, nwen);
      r0 = ren_cnt; w0 = wen_cnt; d0 = done_cnt; o0 = overlap_cnt;
      rd_addr_q.delete();
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a_base = a; bus.b_base = b;
      bus.dst_base = d; bus.len = len;
      @(posedge clk); #1;
      bus.start = 1'b0;
      // Scramble command inputs so only latched values can produce the right result.
      bus.op = ~op; bus.a_base = ~a; bus.b_base = ~b; bus.dst_base = ~d; bus.len = ~len;
      cyc = 1;
      chk({tag, ".busy"}, 64'(bus.busy), 64'(lat > 1));
      while (!bus.done && cyc < 200) begin
         bus.start = (cyc == poke_at);
         @(posedge clk); #1;
         cyc++;
      end
      bus.start = 1'b0;
      chk({tag, ".lat"}, 64'(cyc), 64'(lat));
      chk({tag, ".err"}, 64'(bus.err), 64'(e));
      chk({tag, ".cout"}, 64'(bus.carry_out), 64'(co));
      chk({tag, ".ren"}, 64'(ren_cnt - r0), 64'(nren));
      chk({tag, ".wen"}, 64'(wen_cnt - w0), 64'(nwen));
      @(posedge clk); #1;
      chk({tag, ".done1"}, 64'(done_cnt - d0), 64'd1);
      chk({tag, ".idle"}, 64'({bus.done, bus.busy}), 64'd0);
      diffs = 0;
      for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) diffs++;
      chk({tag, ".mem"}, 64'(diffs), 64'd0);
      chk({tag, ".ovl"}, 64'(overlap_cnt - o0), 64'd0);
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({bus.busy, bus.done, bus.err, bus.carry_out, bus.mem_ren, bus.mem_wen,
                  bus.mem_addr, bus.mem_wdata, bus.alu_cmd, bus.alu_inA, bus.alu_acc, bus.alu_sc_i});
   endfunction

   initial begin
      logic [1:0] r_op;
      logic [3:0] r_len;
      logic [7:0] r_a, r_b, r_d, keep61;
      int r_poke, lat_est, d0, lat, nren, nwen;
      logic e, co;

      bus.start = 1'b0; bus.op = 2'b00; bus.a_base = '0; bus.b_base = '0;
      bus.dst_base = '0; bus.len = '0;
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);

      #12;
      chk("rst.outs", all_outs(), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // ADD len=2 with carry across bytes.
      mem[8'h10] = 8'hFF; mem[8'h11] = 8'h01; mem[8'h20] = 8'h01; mem[8'h21] = 8'h00;
      run_op("add2", 2'b00, 8'h10, 8'h20, 8'h30, 4'd2, -1);
      chk("add2.b0", 64'(mem[8'h30]), 64'h00);
      chk("add2.b1", 64'(mem[8'h31]), 64'h02);

      mem[8'h40] = 8'h80; mem[8'h42] = 8'h80;
      run_op("add1", 2'b00, 8'h40, 8'h42, 8'h44, 4'd1, -1);
      chk("add1.b0", 64'(mem[8'h44]), 64'h00);

      mem[8'h50] = 8'hA5; mem[8'h51] = 8'hFF;
      run_op("xor1", 2'b01, 8'h50, 8'h51, 8'h52, 4'd1, -1);
      chk("xor1.b0", 64'(mem[8'h52]), 64'h5A);

      mem[8'h60] = 8'hFF; mem[8'h61] = 8'h0F; mem[8'h62] = 8'h01;
      run_op("pop3", 2'b10, 8'h60, 8'h00, 8'h70, 4'd3, -1);
      chk("pop3.b0", 64'(mem[8'h70]), 64'd13);

      run_op("len0", 2'b00, 8'h10, 8'h20, 8'h80, 4'd0, -1);
      run_op("rsvd", 2'b11, 8'h10, 8'h20, 8'h80, 4'd5, -1);

      run_op("wrap", 2'b10, 8'hFF, 8'h00, 8'h90, 4'd2, -1);
      chk("wrap.nrd", 64'(rd_addr_q.size()), 64'd2);
      if (rd_addr_q.size() == 2) begin
         chk("wrap.rd0", 64'(rd_addr_q[0]), 64'hFF);
         chk("wrap.rd1", 64'(rd_addr_q[1]), 64'h00);
      end

      run_op("poke", 2'b00, 8'hA0, 8'hB0, 8'hC0, 4'd3, 5);

      // Reset during EXEC of byte 1 of a 2-byte ADD.
      model(2'b00, 8'h40, 8'h50, 8'h60, 4'd2, lat, e, co, nren, nwen);
      keep61 = mem[8'h61];
      d0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b00; bus.a_base = 8'h40; bus.b_base = 8'h50;
      bus.dst_base = 8'h60; bus.len = 4'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      chk("mrst.exec", 64'(bus.alu_cmd), 64'h4);
      rst_n = 1'b0;
      #1;
      chk("mrst.outs", all_outs(), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("mrst.nodone", 64'(done_cnt - d0), 64'd0);
      chk("mrst.b0", 64'(mem[8'h60]), 64'(exp_mem[8'h60]));
      chk("mrst.b1", 64'(mem[8'h61]), 64'(keep61));
      @(negedge clk); rst_n = 1'b1;
      run_op("after", 2'b00, 8'h40, 8'h50, 8'h60, 4'd2, -1);

      for (int t = 0; t < 40; t++) begin
         if (t % 10 == 0) for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
         r_op  = 2'($urandom_range(0, 3));
         r_len = 4'($urandom_range(0, 15));
         r_a   = 8'($urandom);
         r_b   = 8'($urandom);
         r_d   = 8'($urandom);
         lat_est = (r_op == 2'd3 || r_len == 0) ? 1 : 4 * int'(r_len) + 1;
         r_poke = -1;
         if (lat_est >= 5 && $urandom_range(0, 1) == 1) r_poke = int'($urandom_range(2, lat_est - 2));
         run_op($sformatf("rnd%0d", t), r_op, r_a, r_b, r_d, r_len, r_poke);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
